rom_port_arbiter: RTL
=====================

# rom_port_arbiter

Round-robin arbiter and scheduler that shares one fixed-latency synchronous read port between NREQ requesters. Typical shared resources are a sprite ROM, a glyph ROM or the board-state RAM read port. It grants at most one request per cycle and drives the memory address. It carries a tag of each granted request through an internal delay pipeline matched to the memory latency, so every returned word reaches the requester that asked for it. It sits between the drawing stages of the VGA pixel pipeline and the shared memory.

## Interface
Parameters:
- NREQ, 4: number of requesters, 2..8.
- AW, 12: memory address width.
- DW, 8: memory data width.
- LATENCY, 2: memory read latency in cycles, 1..8. Data for an address presented in cycle k is valid on mem_rdata in cycle k+LATENCY.
- IDW (localparam): $clog2(NREQ), the requester ID width.

Ports:
- clk  in  1  posedge clock.
- rst  in  1  synchronous reset, active-low: asserted when rst==0 at a rising clk edge.
- req  in  NREQ  request per requester. Level, held until granted.
- addr  in  NREQ*AW  flattened addresses. Requester i uses addr[i*AW +: AW].
- gnt  out  NREQ  one-hot grant, combinational from req and the priority pointer.
- mem_en  out  1  registered read strobe to memory.
- mem_addr  out  AW  registered read address.
- mem_rdata  in  DW  memory read data.
- rsp_valid  out  1  registered response strobe.
- rsp_id  out  IDW  requester index of the response.
- rsp_data  out  DW  returned word.

## Operation
- Priority pointer `last` (IDW bits) holds the index of the most recently granted requester. Reset value is NREQ-1, so requester 0 has top priority after reset.
- Each cycle, the winner is the first requester with req=1 when scanning last+1, last+2, … wrapping modulo NREQ. gnt is one-hot at the winner and all-zero if there is no request.
- A request is accepted at the clock edge closing a cycle in which gnt[i]=1.
  - The requester may keep req high to issue a back-to-back request with a new addr.
  - A request that is not granted must hold req and addr stable.
- On acceptance:
  - last takes the winner's index.
  - mem_en is 1 next cycle.
  - mem_addr takes the winner's addr next cycle.
  - A tag {1, winner index} enters the tag pipeline.
- With no acceptance: mem_en is 0 next cycle, mem_addr holds its value, last is unchanged, and a tag of {0, 0} enters the pipeline.
- The tag pipeline is LATENCY+1 registers deep, reset to zero. Its output aligns with the cycle in which mem_rdata is valid.
- Response stage: when the pipeline output tag valid=1, register rsp_valid=1, rsp_id=tag id and rsp_data=mem_rdata. Otherwise rsp_valid=0, and rsp_id and rsp_data hold their previous values.
- While rst is 0:
  - gnt is forced to 0, so no acceptance occurs.
  - All registers clear at the edge. Reset values: mem_en=0, mem_addr=0, rsp_valid=0, rsp_id=0, rsp_data=0, all tags 0, last=NREQ-1.
- Reset mid-operation discards every in-flight request. No rsp_valid appears for tags that were in flight.

## Timing
- If gnt is 1 in cycle c:
  - mem_en and mem_addr are valid in cycle c+1.
  - mem_rdata is valid in cycle c+1+LATENCY.
  - rsp_valid, rsp_id and rsp_data are valid in cycle c+2+LATENCY.
- Throughput is one grant per cycle, regardless of how many requesters are active.
- Responses return in grant order. There is no backpressure, so a requester must always accept rsp_valid.
- Fairness: with all NREQ requesters continuously active, each is granted exactly once every NREQ cycles.
- A lone continuous requester is granted every cycle. The pointer wraps from NREQ-1 to 0.
- If a new request appears at the pointer position in the same cycle the current winner drops req, the scan order still applies, with no extra idle cycle.
- Critical path is the round-robin scan plus the NREQ:1 address mux, both combinational in one cycle.

## Test plan
- Reset, then no requests for 10 cycles.
  - Required: gnt=0, mem_en=0 and rsp_valid=0 throughout.
  - Required: mem_addr=0, rsp_id=0 and rsp_data=0 throughout.
- Single request, addr[1]=0x0A5, with a memory model returning addr[7:0]^0x3C and LATENCY=2.
  - req[1] held one cycle, grant in cycle c.
  - Required: mem_en in cycle c+1.
  - Required: rsp_valid in cycle c+4 with rsp_id=1 and rsp_data=0x99.
- All four requesters held high for 12 cycles after reset.
  - Required grant order: 0,1,2,3,0,1,2,3,0,1,2,3.
  - Required: 12 responses in the same ID order, each exactly LATENCY+2 cycles after its grant.
- Requester 2 continuous, requester 0 joins 3 cycles later.
  - Required grants: 2,2,2,0,2,0,2…
  - Required: no idle cycle on mem_en.
- Reset pulse (rst=0 for one cycle) while 3 reads are in flight.
  - Required: rsp_valid=0 for the following LATENCY+2 cycles.
  - Required: the next grant goes to the lowest active index.
- Sweep LATENCY from 1 to 8 with random req/addr over 2000 cycles.
  - Required: every grant produces exactly one response with a matching ID and data.
  - Required: every response arrives in order at c+LATENCY+2.

Source files
------------

// File: rtl/rom_port_arbiter.sv
// Round-robin arbiter sharing one fixed-latency read port.
// Tags follow each grant so every returned word reaches its requester.
module rom_port_arbiter #(
  parameter  int NREQ    = 4,
  parameter  int AW      = 12,
  parameter  int DW      = 8,
  parameter  int LATENCY = 2,
  localparam int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*AW-1:0] addr,
  output logic [NREQ-1:0]   gnt,
  output logic              mem_en,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_rdata,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [DW-1:0]     rsp_data
);

  logic [IDW-1:0] last;
  logic [IDW-1:0] win;
  logic           hit;
  logic [AW-1:0]  sel_addr;
  logic [IDW:0]   tag_q [LATENCY+1];

  // scan last+1 .. last+NREQ, first requester wins
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!hit && rst && req[(int'(last) + k) % NREQ]) begin
        hit = 1'b1;
        win = IDW'((int'(last) + k) % NREQ);
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (hit) gnt[win] = 1'b1;
  end

  assign sel_addr = addr[win*AW +: AW];

  always_ff @(posedge clk) begin
    if (!rst) begin
      last      <= IDW'(NREQ - 1);
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
      for (int i = 0; i <= LATENCY; i++) tag_q[i] <= '0;
    end else begin
      mem_en <= hit;
      if (hit) begin
        last     <= win;
        mem_addr <= sel_addr;
      end
      tag_q[0] <= hit ? {1'b1, win} : '0;
      for (int i = 1; i <= LATENCY; i++) tag_q[i] <= tag_q[i-1];
      rsp_valid <= tag_q[LATENCY][IDW];
      if (tag_q[LATENCY][IDW]) begin
        rsp_id   <= tag_q[LATENCY][IDW-1:0];
        rsp_data <= mem_rdata;
      end
    end
  end

endmodule
